// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter state encoding and BCD digit constants.
package calc_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/result_bcd_converter_digit_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the next left shift.
module bcd_digit_adjust
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with a
// start/ready/done handshake; bcd_out holds the last result for the display.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [IN_W-1:0]             bin_in,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  state_e           state_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] bcd_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  // BCD field sits above the binary field; every digit is corrected before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sr_q  [IN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (sr_adj[IN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign sr_adj[IN_W-1:0] = sr_q[IN_W-1:0];
  assign sr_d             = sr_adj << 1;

  // NOTE: sequential state uses non-blocking assignments only; the shifted value is
  // computed combinationally so the DONE-entry edge can capture the final shift directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sr_q    <= {{BCD_W{1'b0}}, bin_in};
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= sr_d[SR_W-1 -: BCD_W];
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: expected BCD pushed at stimulus time,
// popped and compared on every done pulse; scenario tasks check timing and flags inline.
module tb_result_bcd_converter;

  localparam int IN_W   = 9;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int LAT    = IN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IN_W-1:0]  bin_in = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic rst_seen = 1'b0;
  logic [BCD_W-1:0] prev_bcd = '0;
  logic [BCD_W-1:0] exp_q[$];

  result_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Scoreboard and invariant monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [BCD_W-1:0] exp_v;
      n_checks++;
      if (int'(ready) + int'(busy) + int'(done) != 1) begin
        n_fail++;
        $display("FAIL flags_onehot cyc=%0d ready=%b busy=%b done=%b", cyc, ready, busy, done);
      end
      for (int d = 0; d < DIGITS; d++) begin
        n_checks++;
        if (bcd_out[4*d +: 4] > 4'd9) begin
          n_fail++;
          $display("FAIL digit_range cyc=%0d digit%0d=%h", cyc, d, bcd_out[4*d +: 4]);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done cyc=%0d bcd_out=%h expected no done", cyc, bcd_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (bcd_out !== exp_v) begin
            n_fail++;
            $display("FAIL scoreboard_bcd cyc=%0d got=%h expected=%h", cyc, bcd_out, exp_v);
          end
        end
      end else if (rst_seen === 1'b1) begin
        n_checks++;
        if (bcd_out !== prev_bcd) begin
          n_fail++;
          $display("FAIL bcd_stable cyc=%0d got=%h expected=%h", cyc, bcd_out, prev_bcd);
        end
      end
      prev_bcd = bcd_out;
    end
  end

  task automatic wait_done(output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    bin_in = 9'd77;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got ready=%b busy=%b done=%b expected 1/0/0", ready, busy, done);
    end
    n_checks++;
    if (bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bcd got=%h expected=000", bcd_out);
    end
  endtask

  task automatic test_convert(input int v);
    int e0, at;
    bit ok;
    logic [BCD_W-1:0] exp_v;
    exp_v = to_bcd(v);
    exp_q.push_back(exp_v);
    bin_in = IN_W'(v);
    start  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 9'h0AA;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL convert_busy v=%0d got busy=%b ready=%b expected 1/0", v, busy, ready);
    end
    wait_done(at, ok);
    n_checks++;
    if (!ok || at != e0 + LAT) begin
      n_fail++;
      $display("FAIL convert_latency v=%0d done_at=%0d expected=%0d", v, at - e0, LAT);
    end
    n_checks++;
    if (bcd_out !== exp_v) begin
      n_fail++;
      $display("FAIL convert_bcd v=%0d got=%h expected=%h", v, bcd_out, exp_v);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || bcd_out !== exp_v) begin
      n_fail++;
      $display("FAIL convert_return v=%0d got ready=%b done=%b bcd=%h expected 1/0/%h",
               v, ready, done, bcd_out, exp_v);
    end
  endtask

  task automatic test_ignored_start();
    int e0, at, dc0;
    bit ok;
    exp_q.push_back(12'h042);
    dc0 = done_cnt;
    bin_in = 9'd42;
    start  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 2) @(negedge clk);
    start  = 1'b1;
    bin_in = 9'd7;
    @(negedge clk);
    start  = 1'b0;
    wait_done(at, ok);
    n_checks++;
    if (!ok || at != e0 + LAT || bcd_out !== 12'h042) begin
      n_fail++;
      $display("FAIL ignored_start_result done_at=%0d bcd=%h expected %0d/042", at - e0, bcd_out, LAT);
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if (done_cnt != dc0 + 1) begin
      n_fail++;
      $display("FAIL ignored_start_pulses got=%0d expected=1", done_cnt - dc0);
    end
  endtask

  task automatic test_reset_mid();
    int e0, dc0;
    dc0 = done_cnt;
    bin_in = 9'd300;
    start  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_abort got ready=%b busy=%b bcd=%h expected 1/0/000", ready, busy, bcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    n_checks++;
    if (done_cnt != dc0 || ready !== 1'b1 || bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_after got pulses=%0d ready=%b bcd=%h expected 0/1/000",
               done_cnt - dc0, ready, bcd_out);
    end
  endtask

  task automatic test_back_to_back();
    int e0, at;
    bit ok;
    exp_q.push_back(12'h123);
    exp_q.push_back(12'h456);
    bin_in = 9'd123;
    start  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bin_in = 9'd456;
    wait_done(at, ok);
    n_checks++;
    if (!ok || at != e0 + LAT || bcd_out !== 12'h123) begin
      n_fail++;
      $display("FAIL b2b_first done_at=%0d bcd=%h expected %0d/123", at - e0, bcd_out, LAT);
    end
    while (cyc < e0 + LAT + 2) @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 15) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || bcd_out !== 12'h123) begin
      n_fail++;
      $display("FAIL b2b_hold got busy=%b bcd=%h expected 1/123", busy, bcd_out);
    end
    wait_done(at, ok);
    n_checks++;
    if (!ok || at != e0 + 2 * LAT + 2 || bcd_out !== 12'h456) begin
      n_fail++;
      $display("FAIL b2b_second done_at=%0d bcd=%h expected %0d/456", at - e0, bcd_out, 2 * LAT + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert(0);
    test_convert(511);
    test_convert(100);
    test_convert(255);
    test_convert(99);
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
